// File: rtl/micro_seq_pkg.sv
// Shared encodings for the micro-program sequencer: word field positions,
// microinstruction types, sequencer states and the branch-condition helper.
package micro_seq_pkg;

    localparam int unsigned TYPE_HI = 31;
    localparam int unsigned TYPE_LO = 29;
    localparam int unsigned INV_BIT = 28;
    localparam int unsigned SEL_HI  = 27;
    localparam int unsigned SEL_LO  = 24;
    localparam int unsigned TGT_LO  = 16;
    localparam int unsigned CTRL_LO = 0;

    localparam int unsigned BOOT_ADDR = 0;

    typedef enum logic [2:0] {
        UT_SEQ  = 3'd0,
        UT_JMP  = 3'd1,
        UT_BR   = 3'd2,
        UT_CALL = 3'd3,
        UT_RET  = 3'd4,
        UT_DISP = 3'd5,
        UT_HALT = 3'd6,
        UT_SEQ7 = 3'd7
    } utype_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAITD = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic logic cond_taken(input logic [15:0] cond,
                                        input logic [3:0]  sel,
                                        input logic        inv);
        return cond[sel] ^ inv;
    endfunction

endpackage

// File: rtl/micro_ret_stack.sv
// Circular LIFO of micro-subroutine return addresses; overflow overwrites the
// oldest entry, underflow returns 0, and either condition sets a sticky error.
module micro_ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = empty ? '0 : mem[sp - PTR_W'(1)];

    // With a power-of-two depth the write pointer wraps onto the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
            err   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + PTR_W'(1);
            if (full) begin
                err <= 1'b1;
            end else begin
                count <= count + (PTR_W+1)'(1);
            end
        end else if (pop) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                sp    <= sp - PTR_W'(1);
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Zero-bubble micro-program sequencer: the main ROM port fetches fall-through or
// dispatch words, the speculative port fetches the MIR target, condition picks one.
module micro_sequencer #(
    parameter int unsigned UADDR_W = 8,
    parameter int unsigned UWORD_W = 32,
    parameter int unsigned CTRL_W  = 16,
    parameter int unsigned STACK_D = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [UADDR_W-1:0] micro_code_addr_out,
    input  logic [UWORD_W-1:0] micro_code_data_in,
    output logic [UADDR_W-1:0] micro_code_spec_addr_out,
    input  logic [UWORD_W-1:0] micro_code_spec_data_in,
    input  logic [15:0]        cond_in,
    input  logic [UADDR_W-1:0] dispatch_addr_in,
    input  logic               instr_valid_in,
    output logic               instr_ready_out,
    input  logic               stall_in,
    input  logic               flush_in,
    input  logic [UADDR_W-1:0] flush_addr_in,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic               ctrl_valid_out,
    output logic [UADDR_W-1:0] upc_out,
    output logic               halted_out,
    output logic               stack_err_out
);

    import micro_seq_pkg::*;

    state_t             state, state_nxt;
    logic [UWORD_W-1:0] mir, mir_nxt;
    logic [UADDR_W-1:0] upc, upc_nxt;
    logic               valid, valid_nxt;
    logic               halted, halted_nxt;
    logic [UADDR_W-1:0] main_addr;
    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] tgt;
    logic [UADDR_W-1:0] pop_data;
    logic               push, pop, ready;
    logic               taken;
    utype_t             mtype;

    assign mtype   = utype_t'(mir[TYPE_HI:TYPE_LO]);
    assign tgt     = mir[TGT_LO +: UADDR_W];
    assign upc_inc = upc + UADDR_W'(1);
    assign taken   = cond_taken(cond_in, mir[SEL_HI:SEL_LO], mir[INV_BIT]);

    micro_ret_stack #(
        .DEPTH (STACK_D),
        .WIDTH (UADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .pop_data  (pop_data),
        .err       (stack_err_out)
    );

    always_comb begin
        state_nxt  = state;
        mir_nxt    = mir;
        upc_nxt    = upc;
        valid_nxt  = valid;
        halted_nxt = halted;
        main_addr  = upc_inc;
        push       = 1'b0;
        pop        = 1'b0;
        ready      = 1'b0;

        case (state)
            ST_BOOT: begin
                main_addr = UADDR_W'(BOOT_ADDR);
                if (!stall_in) begin
                    mir_nxt   = micro_code_data_in;
                    upc_nxt   = UADDR_W'(BOOT_ADDR);
                    valid_nxt = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mtype == UT_DISP) begin
                    main_addr = dispatch_addr_in;
                end else if (mtype == UT_RET) begin
                    main_addr = pop_data;
                end
                if (!stall_in) begin
                    case (mtype)
                        UT_JMP: begin
                            mir_nxt = micro_code_spec_data_in;
                            upc_nxt = tgt;
                        end
                        UT_BR: begin
                            mir_nxt = taken ? micro_code_spec_data_in : micro_code_data_in;
                            upc_nxt = taken ? tgt : main_addr;
                        end
                        UT_CALL: begin
                            push    = 1'b1;
                            mir_nxt = micro_code_spec_data_in;
                            upc_nxt = tgt;
                        end
                        UT_RET: begin
                            pop     = 1'b1;
                            mir_nxt = micro_code_data_in;
                            upc_nxt = main_addr;
                        end
                        UT_DISP: begin
                            if (instr_valid_in) begin
                                ready   = 1'b1;
                                mir_nxt = micro_code_data_in;
                                upc_nxt = main_addr;
                            end else begin
                                valid_nxt = 1'b0;
                                state_nxt = ST_WAITD;
                            end
                        end
                        UT_HALT: begin
                            valid_nxt  = 1'b0;
                            halted_nxt = 1'b1;
                            state_nxt  = ST_HALT;
                        end
                        default: begin
                            mir_nxt = micro_code_data_in;
                            upc_nxt = main_addr;
                        end
                    endcase
                end
            end
            ST_WAITD: begin
                main_addr = dispatch_addr_in;
                if (!stall_in && instr_valid_in) begin
                    ready     = 1'b1;
                    mir_nxt   = micro_code_data_in;
                    upc_nxt   = main_addr;
                    valid_nxt = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: ;
        endcase

        // Flush overrides everything decided above, including stall and stack ops.
        if (flush_in && (state == ST_RUN || state == ST_WAITD)) begin
            main_addr  = flush_addr_in;
            mir_nxt    = micro_code_data_in;
            upc_nxt    = flush_addr_in;
            valid_nxt  = 1'b1;
            halted_nxt = halted;
            state_nxt  = ST_RUN;
            push       = 1'b0;
            pop        = 1'b0;
            ready      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_BOOT;
            mir    <= '0;
            upc    <= '0;
            valid  <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            mir    <= mir_nxt;
            upc    <= upc_nxt;
            valid  <= valid_nxt;
            halted <= halted_nxt;
        end
    end

    assign micro_code_addr_out      = main_addr;
    assign micro_code_spec_addr_out = tgt;
    assign instr_ready_out          = ready;
    assign ctrl_out                 = valid ? mir[CTRL_LO +: CTRL_W] : '0;
    assign ctrl_valid_out           = valid;
    assign upc_out                  = upc;
    assign halted_out               = halted;

endmodule
